// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported memory: one access per cycle,
// pending slots beat fresh requests, round-robin or fixed priority between equals.
module mem_arbiter #(
    parameter int CNT_W      = 16,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      m0_addr,
    input  logic             m0_rstrb,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_wmask,
    output logic [31:0]      m0_rdata,
    output logic             m0_rbusy,
    output logic             m0_wbusy,
    input  logic [31:0]      m1_addr,
    input  logic             m1_rstrb,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_wmask,
    output logic [31:0]      m1_rdata,
    output logic             m1_rbusy,
    output logic             m1_wbusy,
    output logic [31:0]      mem_addr,
    output logic             mem_rstrb,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, PEND_RD = 2'd1, PEND_WR = 2'd2} slot_e;

    slot_e            slot_r       [2];
    logic [31:0]      slot_addr_r  [2];
    logic [31:0]      slot_wdata_r [2];
    logic [3:0]       slot_wmask_r [2];
    logic [31:0]      rdata_r      [2];
    logic [1:0]       rd_pend_r;
    logic             rr_r;
    logic [CNT_W-1:0] cnt_r;

    logic [31:0]      req_addr_s   [2];
    logic [31:0]      req_wdata_s  [2];
    logic [3:0]       req_wmask_s  [2];
    logic [1:0]       req_rstrb_s;
    logic [1:0]       occ_s;
    logic [1:0]       cand_s;
    logic [1:0]       cand_wr_s;
    logic [31:0]      cand_addr_s  [2];
    logic [31:0]      cand_wdata_s [2];
    logic [3:0]       cand_wmask_s [2];
    logic             win_s;
    logic             issue_s;
    logic             both_s;

    // Per-port candidate: the latched slot if occupied, otherwise the live request
    always_comb begin
        req_addr_s[0]  = m0_addr;
        req_addr_s[1]  = m1_addr;
        req_wdata_s[0] = m0_wdata;
        req_wdata_s[1] = m1_wdata;
        req_wmask_s[0] = m0_wmask;
        req_wmask_s[1] = m1_wmask;
        req_rstrb_s    = {m1_rstrb, m0_rstrb};
        for (int p = 0; p < 2; p++) begin
            occ_s[p] = (slot_r[p] != EMPTY);
            if (occ_s[p]) begin
                cand_s[p]       = 1'b1;
                cand_wr_s[p]    = (slot_r[p] == PEND_WR);
                cand_addr_s[p]  = slot_addr_r[p];
                cand_wdata_s[p] = slot_wdata_r[p];
                cand_wmask_s[p] = slot_wmask_r[p];
            end else begin
                // a write strobe swallows a simultaneous read strobe
                cand_wr_s[p]    = (req_wmask_s[p] != 4'h0);
                cand_s[p]       = req_rstrb_s[p] | cand_wr_s[p];
                cand_addr_s[p]  = req_addr_s[p];
                cand_wdata_s[p] = req_wdata_s[p];
                cand_wmask_s[p] = req_wmask_s[p];
            end
        end
    end

    // Winner selection and memory-side drive
    always_comb begin
        both_s  = cand_s[0] & cand_s[1];
        issue_s = rst_n & (cand_s[0] | cand_s[1]);
        if (!cand_s[0]) begin
            win_s = 1'b1;
        end else if (!cand_s[1]) begin
            win_s = 1'b0;
        end else if (occ_s[0] != occ_s[1]) begin
            win_s = occ_s[1];
        end else if (FIXED_PRIO) begin
            win_s = 1'b0;
        end else begin
            win_s = rr_r;
        end
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        if (issue_s) begin
            mem_addr  = cand_addr_s[win_s];
            mem_wdata = cand_wdata_s[win_s];
            mem_wmask = cand_wr_s[win_s] ? cand_wmask_s[win_s] : 4'h0;
            mem_rstrb = ~cand_wr_s[win_s];
        end else begin
            mem_rstrb = 1'b0;
        end
    end

    // Slot, read-data, round-robin and conflict-counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                slot_r[p]       <= EMPTY;
                slot_addr_r[p]  <= 32'h0;
                slot_wdata_r[p] <= 32'h0;
                slot_wmask_r[p] <= 4'h0;
                rdata_r[p]      <= 32'h0;
            end
            rd_pend_r <= 2'b00;
            rr_r      <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (issue_s && (win_s == 1'(p))) begin
                    slot_r[p] <= EMPTY;
                end else if (!occ_s[p] && cand_s[p]) begin
                    slot_r[p]       <= cand_wr_s[p] ? PEND_WR : PEND_RD;
                    slot_addr_r[p]  <= req_addr_s[p];
                    slot_wdata_r[p] <= req_wdata_s[p];
                    slot_wmask_r[p] <= req_wmask_s[p];
                end
                rd_pend_r[p] <= issue_s && (win_s == 1'(p)) && !cand_wr_s[p];
                if (rd_pend_r[p]) begin
                    rdata_r[p] <= mem_rdata;
                end
            end
            if (both_s) begin
                rr_r <= ~win_s;
                if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Memory data is forwarded in the cycle it arrives, then held from the register
    assign m0_rdata     = rd_pend_r[0] ? mem_rdata : rdata_r[0];
    assign m1_rdata     = rd_pend_r[1] ? mem_rdata : rdata_r[1];
    assign m0_rbusy     = (slot_r[0] == PEND_RD);
    assign m0_wbusy     = (slot_r[0] == PEND_WR);
    assign m1_rbusy     = (slot_r[1] == PEND_RD);
    assign m1_wbusy     = (slot_r[1] == PEND_WR);
    assign conflict_cnt = cnt_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a memory model,
// plus a fixed-priority 4-bit-counter instance for priority and saturation.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_rstrb, m1_rstrb, m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
    logic [3:0]  m0_wmask, m1_wmask, mem_wmask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rstrb;
    logic [15:0] conflict_cnt;

    logic [31:0] f_m0_addr, f_m1_addr, f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;
    logic        f_m0_rstrb, f_m1_rstrb, f_m0_rbusy, f_m0_wbusy, f_m1_rbusy, f_m1_wbusy, f_mem_rstrb;
    logic [3:0]  f_mem_wmask;
    logic [3:0]  f_cnt;
    logic [31:0] f_mem_rdata = 32'hCAFE_F00D;

    logic [31:0] mem [0:255];
    logic [31:0] exp0_q [$];
    logic [31:0] exp1_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.CNT_W(16), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    mem_arbiter #(.CNT_W(4), .FIXED_PRIO(1'b1)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(f_m0_addr), .m0_rstrb(f_m0_rstrb), .m0_wdata(32'h0), .m0_wmask(4'h0),
        .m0_rdata(f_m0_rdata), .m0_rbusy(f_m0_rbusy), .m0_wbusy(f_m0_wbusy),
        .m1_addr(f_m1_addr), .m1_rstrb(f_m1_rstrb), .m1_wdata(32'h0), .m1_wmask(4'h0),
        .m1_rdata(f_m1_rdata), .m1_rbusy(f_m1_rbusy), .m1_wbusy(f_m1_wbusy),
        .mem_addr(f_mem_addr), .mem_rstrb(f_mem_rstrb), .mem_wdata(f_mem_wdata),
        .mem_wmask(f_mem_wmask), .mem_rdata(f_mem_rdata), .conflict_cnt(f_cnt)
    );

    // Word-addressed memory with byte enables; read data one cycle after the strobe
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        m0_addr = 32'h0; m0_rstrb = 1'b0; m0_wdata = 32'h0; m0_wmask = 4'h0;
        m1_addr = 32'h0; m1_rstrb = 1'b0; m1_wdata = 32'h0; m1_wmask = 4'h0;
        f_m0_addr = 32'h0; f_m0_rstrb = 1'b0; f_m1_addr = 32'h0; f_m1_rstrb = 1'b0;
    endtask

    task automatic collide();
        m0_rstrb = 1'b1; m0_addr = 32'h10;
        m1_rstrb = 1'b1; m1_addr = 32'h20;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'h1111_1111;
        mem[8'h08] = 32'h2222_2222;
        mem[8'h40] = 32'hDEAD_BEEF;
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        idle();
        repeat (2) cyc();
        smp();
        chk("rst_m0_rbusy", {31'h0, m0_rbusy}, 32'h0);
        chk("rst_m1_wbusy", {31'h0, m1_wbusy}, 32'h0);
        chk("rst_mem_rstrb", {31'h0, mem_rstrb}, 32'h0);
        chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        chk("rst_cnt", {16'h0, conflict_cnt}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        cyc();
        rst_n = 1'b1;

        // lone read, zero added latency
        m0_rstrb = 1'b1; m0_addr = 32'h100; exp0_q.push_back(32'hDEAD_BEEF);
        smp();
        chk("solo_rstrb", {31'h0, mem_rstrb}, 32'h1);
        chk("solo_addr", mem_addr, 32'h100);
        chk("solo_rbusy", {31'h0, m0_rbusy}, 32'h0);
        cyc(); idle();
        smp();
        chk("solo_rdata", m0_rdata, exp0_q.pop_front());
        chk("solo_rbusy_t1", {31'h0, m0_rbusy}, 32'h0);
        chk("idle_rstrb", {31'h0, mem_rstrb}, 32'h0);
        m0_addr = 32'h0000_0ABC; m0_wdata = 32'h5A5A_0000;
        #1;
        chk("idle_addr", mem_addr, 32'h0000_0ABC);
        chk("idle_wdata", mem_wdata, 32'h5A5A_0000);
        cyc(); idle();
        smp();
        chk("solo_hold", m0_rdata, 32'hDEAD_BEEF);

        // first collision: rr=0, port 0 wins
        cyc(); collide(); exp0_q.push_back(32'h1111_1111);
        smp();
        chk("c1_addr", mem_addr, 32'h10);
        chk("c1_rstrb", {31'h0, mem_rstrb}, 32'h1);
        cyc(); idle(); exp1_q.push_back(32'h2222_2222);
        smp();
        chk("c1_m1_rbusy", {31'h0, m1_rbusy}, 32'h1);
        chk("c1_addr_t1", mem_addr, 32'h20);
        chk("c1_m0_rdata", m0_rdata, exp0_q.pop_front());
        cyc();
        smp();
        chk("c1_m1_rdata", m1_rdata, exp1_q.pop_front());
        chk("c1_m1_rbusy_t2", {31'h0, m1_rbusy}, 32'h0);
        chk("c1_cnt", {16'h0, conflict_cnt}, 32'd1);

        // second collision: rr=1, port 1 wins
        cyc(); collide(); exp1_q.push_back(32'h2222_2222);
        smp();
        chk("c2_addr", mem_addr, 32'h20);
        cyc(); idle(); exp0_q.push_back(32'h1111_1111);
        smp();
        chk("c2_m0_rbusy", {31'h0, m0_rbusy}, 32'h1);
        chk("c2_addr_t1", mem_addr, 32'h10);
        chk("c2_m1_rdata", m1_rdata, exp1_q.pop_front());
        cyc();
        smp();
        chk("c2_m0_rdata", m0_rdata, exp0_q.pop_front());
        chk("c2_cnt", {16'h0, conflict_cnt}, 32'd2);

        // third collision: back to port 0, leaves rr=1
        cyc(); collide(); exp0_q.push_back(32'h1111_1111);
        smp();
        chk("c3_addr", mem_addr, 32'h10);
        cyc(); idle(); exp1_q.push_back(32'h2222_2222);
        smp();
        chk("c3_m0_rdata", m0_rdata, exp0_q.pop_front());
        cyc();
        smp();
        chk("c3_m1_rdata", m1_rdata, exp1_q.pop_front());
        chk("c3_cnt", {16'h0, conflict_cnt}, 32'd3);

        // write on port 1 vs read of same address on port 0, rr=1
        cyc();
        m1_wmask = 4'hF; m1_wdata = 32'h1234_5678; m1_addr = 32'h40;
        m0_rstrb = 1'b1; m0_addr = 32'h40; exp0_q.push_back(32'h1234_5678);
        smp();
        chk("wr_wmask", {28'h0, mem_wmask}, 32'hF);
        chk("wr_rstrb", {31'h0, mem_rstrb}, 32'h0);
        chk("wr_addr", mem_addr, 32'h40);
        chk("wr_wdata", mem_wdata, 32'h1234_5678);
        cyc(); idle();
        smp();
        chk("wr_m0_rbusy", {31'h0, m0_rbusy}, 32'h1);
        chk("wr_rd_addr", mem_addr, 32'h40);
        cyc();
        smp();
        chk("wr_raw_rdata", m0_rdata, exp0_q.pop_front());
        chk("wr_cnt", {16'h0, conflict_cnt}, 32'd4);

        // read and write strobes together: write wins, read dropped
        cyc();
        m1_rstrb = 1'b1; m1_wmask = 4'h3; m1_wdata = 32'hAAAA_5555; m1_addr = 32'h40;
        smp();
        chk("rw_wmask", {28'h0, mem_wmask}, 32'h3);
        chk("rw_rstrb", {31'h0, mem_rstrb}, 32'h0);
        cyc(); idle();
        smp();
        chk("rw_rbusy", {31'h0, m1_rbusy}, 32'h0);
        chk("rw_rstrb_t1", {31'h0, mem_rstrb}, 32'h0);
        cyc(); m0_rstrb = 1'b1; m0_addr = 32'h40; exp0_q.push_back(32'h1234_5555);
        cyc(); idle();
        smp();
        chk("rw_bytes", m0_rdata, exp0_q.pop_front());

        // losing write gets parked (rr=0 so port 0 read wins)
        cyc();
        m0_rstrb = 1'b1; m0_addr = 32'h10; exp0_q.push_back(32'h1111_1111);
        m1_wmask = 4'hF; m1_wdata = 32'h0BAD_F00D; m1_addr = 32'h44;
        smp();
        chk("pw_addr", mem_addr, 32'h10);
        cyc(); idle();
        smp();
        chk("pw_wbusy", {31'h0, m1_wbusy}, 32'h1);
        chk("pw_wmask", {28'h0, mem_wmask}, 32'hF);
        chk("pw_addr_t1", mem_addr, 32'h44);
        chk("pw_m0_rdata", m0_rdata, exp0_q.pop_front());
        cyc();
        smp();
        chk("pw_wbusy_t2", {31'h0, m1_wbusy}, 32'h0);
        chk("pw_cnt", {16'h0, conflict_cnt}, 32'd5);
        cyc(); m1_rstrb = 1'b1; m1_addr = 32'h44; exp1_q.push_back(32'h0BAD_F00D);
        cyc(); idle();
        smp();
        chk("pw_readback", m1_rdata, exp1_q.pop_front());

        // rr=1: port 1 wins, rr returns to 0
        cyc(); collide(); exp1_q.push_back(32'h2222_2222);
        smp();
        chk("c6_addr", mem_addr, 32'h20);
        cyc(); idle(); exp0_q.push_back(32'h1111_1111);
        smp();
        chk("c6_m1_rdata", m1_rdata, exp1_q.pop_front());
        cyc();
        smp();
        chk("c6_m0_rdata", m0_rdata, exp0_q.pop_front());

        // reset while port 1 read is parked
        cyc(); collide();
        smp();
        chk("c7_addr", mem_addr, 32'h10);
        cyc(); idle();
        smp();
        chk("c7_m1_rbusy", {31'h0, m1_rbusy}, 32'h1);
        chk("c7_cnt", {16'h0, conflict_cnt}, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("ar_m1_rbusy", {31'h0, m1_rbusy}, 32'h0);
        chk("ar_rstrb", {31'h0, mem_rstrb}, 32'h0);
        chk("ar_cnt", {16'h0, conflict_cnt}, 32'h0);
        chk("ar_m0_rdata", m0_rdata, 32'h0);
        cyc();
        chk("ar_rstrb_edge", {31'h0, mem_rstrb}, 32'h0);
        rst_n = 1'b1;
        m0_rstrb = 1'b1; m0_addr = 32'h100; exp0_q.push_back(32'hDEAD_BEEF);
        smp();
        chk("post_rst_rstrb", {31'h0, mem_rstrb}, 32'h1);
        cyc(); idle();
        smp();
        chk("post_rst_rdata", m0_rdata, exp0_q.pop_front());
        chk("post_rst_cnt", {16'h0, conflict_cnt}, 32'h0);

        // fixed-priority instance: port 0 wins both collisions
        cyc();
        f_m0_rstrb = 1'b1; f_m0_addr = 32'h10; f_m1_rstrb = 1'b1; f_m1_addr = 32'h20;
        smp();
        chk("fx1_addr", f_mem_addr, 32'h10);
        cyc(); idle();
        smp();
        chk("fx1_m1_rbusy", {31'h0, f_m1_rbusy}, 32'h1);
        chk("fx1_m0_rdata", f_m0_rdata, 32'hCAFE_F00D);
        cyc(); cyc();
        f_m0_rstrb = 1'b1; f_m0_addr = 32'h10; f_m1_rstrb = 1'b1; f_m1_addr = 32'h20;
        smp();
        chk("fx2_addr", f_mem_addr, 32'h10);
        cyc(); idle(); cyc(); cyc();
        smp();
        chk("fx2_cnt", {28'h0, f_cnt}, 32'd2);

        // continuous contention: every cycle collides, counter must stop at all-ones
        cyc();
        f_m0_rstrb = 1'b1; f_m0_addr = 32'h10; f_m1_rstrb = 1'b1; f_m1_addr = 32'h20;
        repeat (19) cyc();
        idle();
        cyc(); cyc();
        smp();
        chk("sat_cnt", {28'h0, f_cnt}, 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter CNT_W, default 16, giving the width of the conflict counter.
REQ-002 The block SHALL take parameter FIXED_PRIO, default 0; 0 selects round-robin, 1 means port 0 always wins.
REQ-003 The block SHALL have the ports below; one clock; reset asynchronous, active-low:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  m0_addr / m1_addr  in  32  requester byte address
  m0_rstrb / m1_rstrb  in  1  read strobe, one cycle
  m0_wdata / m1_wdata  in  32  write data
  m0_wmask / m1_wmask  in  4  byte write enables, nonzero = write strobe
  m0_rdata / m1_rdata  out  32  read data
  m0_rbusy / m1_rbusy  out  1  read pending
  m0_wbusy / m1_wbusy  out  1  write pending
  mem_addr  out  32  shared memory address
  mem_rstrb  out  1  memory read strobe
  mem_wdata  out  32  memory write data
  mem_wmask  out  4  memory byte enables
  mem_rdata  in  32  memory data, valid the cycle after mem_rstrb
  conflict_cnt  out  CNT_W  count of same-cycle collisions

Function
REQ-004 A port request SHALL be rstrb=1 or wmask!=0 while that port's rbusy=0 and wbusy=0; strobes while busy SHALL be ignored.
REQ-005 If rstrb and wmask!=0 arrive together on one port, the block SHALL serve the write and drop the read.
REQ-006 Each port SHALL have one slot with states EMPTY, PEND_RD and PEND_WR, which latches addr, wdata and wmask.
REQ-007 Each cycle the block SHALL issue at most one access to memory; an occupied slot SHALL beat a new request.
REQ-008 Between two candidates of equal class, the winner SHALL be the rr pointer port; with FIXED_PRIO=1 it SHALL always be port 0.
REQ-009 After each cycle where both ports had candidates, rr SHALL point to the loser; otherwise rr SHALL hold.
REQ-010 The winning request SHALL drive mem_* combinationally in the same cycle, giving zero added latency when uncontended.
REQ-011 A losing new request SHALL be latched; its slot goes to PEND_RD or PEND_WR at the next edge.
REQ-012 rbusy SHALL equal (slot==PEND_RD) and wbusy SHALL equal (slot==PEND_WR), both registered.
REQ-013 An issued slot SHALL return to EMPTY at the end of its issue cycle.
REQ-014 A read issued in cycle T SHALL make the port's rdata equal mem_rdata in cycle T+1, bypassed combinationally.
REQ-015 That read data SHALL also be registered and held on rdata until the port's next read completes.
REQ-016 A write SHALL complete in its issue cycle, and no mem_rdata capture SHALL occur for it.
REQ-017 With nothing issued, the block SHALL drive mem_rstrb=0, mem_wmask=0, mem_addr=m0_addr and mem_wdata=m0_wdata.
REQ-018 conflict_cnt SHALL increment once per cycle in which both ports had candidates, and SHALL saturate at all-ones.
REQ-019 A write followed by a read to the same address SHALL be ordered by issue cycle, and the read SHALL return the written data.

Reset
REQ-020 While rst_n=0, asynchronously: slots EMPTY, rr=0, rdata registers 0, conflict_cnt 0, all busy outputs 0, mem_rstrb=0, mem_wmask=0.
REQ-021 Reset during an occupied slot or read data phase SHALL drop the access without any memory strobe.
REQ-022 The first edge after rst_n rises SHALL accept requests normally.

Verification
REQ-023 Port 0 read of 0x100 alone, memory holds 0xDEADBEEF -> mem_rstrb in cycle T, m0_rdata=0xDEADBEEF in T+1, m0_rbusy stays 0.
REQ-024 Both ports read in the same cycle after reset (0x10, 0x20) -> port 0 issues at T, port 1 issues at T+1 with m1_rbusy=1 during T+1, m1_rdata valid at T+2, conflict_cnt=1.
REQ-025 A second simultaneous collision -> port 1 wins (round-robin), conflict_cnt=2; with FIXED_PRIO=1 port 0 wins both.
REQ-026 Port 1 writes 0x12345678 with wmask 4'b1111 to 0x40 while port 0 reads 0x40 in the same cycle (rr=1) -> write issues first, and m0_rdata=0x12345678.
REQ-027 rst_n pulled low while m1_rbusy=1 -> busy flags clear immediately, no mem_rstrb for the dropped read, conflict_cnt=0.
REQ-028 Force 2^CNT_W+3 collisions with CNT_W=4 -> conflict_cnt saturates at 4'hF.
